// File: rtl/spi_mem_responder.sv
// rtl/spi_mem_responder.sv - SPI mode-0 serial memory responder with status register
//
// Oversamples an SPI initiator in the clk domain, decodes READ/WRITE/RDSR/WREN/WRDI
// frames and serves a 2^ADDR_BITS byte register array.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   sclk      SPI clock from the initiator (idle low)
//   cs_n      chip select, active low
//   mosi      serial data in, MSB first
//   miso      serial data out, MSB first (0 when not driven)
//   miso_oe   high while the responder drives miso (RD and STAT states)
//   selected  registered, synchronized ~cs_n
//   wel       write-enable latch (status bit 1)
module spi_mem_responder #(
    parameter int ADDR_BITS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic selected,
    output logic wel
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int SW    = $clog2(SYNC_STAGES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SYNC_STAGES);

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRDI  = 8'h04;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_WREN  = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_STAT,
        ST_IGNORE
    } state_t;

    state_t state, state_next;

    // Input synchronizers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_prev, cs_prev;
    logic [SW-1:0] settle_cnt;
    logic armed;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    // Datapath
    logic [7:0] mem [DEPTH];
    logic [2:0] bit_cnt;
    logic [1:0] addr_byte;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [ADDR_BITS-1:0] addr;
    logic is_read;
    logic wel_q;
    logic wel_set_pend;
    logic wel_clr_pend;
    logic miso_q;

    logic [7:0] rx_byte;
    logic byte_done;
    logic [ADDR_BITS-1:0] addr_shifted;
    logic [ADDR_BITS-1:0] addr_inc;
    logic [7:0] status_byte;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    // A fall is only honoured once CS has been seen high after reset, so a
    // frame interrupted by reset is ignored until the initiator deselects.
    assign cs_fall   = armed & ~cs_s & cs_prev;

    assign rx_byte      = {rx_shift[6:0], mosi_s};
    assign byte_done    = sclk_rise && (bit_cnt == 3'd7);
    assign addr_shifted = {addr[ADDR_BITS-2:0], mosi_s};
    assign addr_inc     = addr + 1'b1;
    assign status_byte  = {6'b0, wel_q, 1'b0};

    assign wel  = wel_q;
    assign miso = miso_oe & miso_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            sclk_prev  <= 1'b0;
            cs_prev    <= 1'b1;
            settle_cnt <= '0;
            armed      <= 1'b0;
            selected   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            selected  <= ~cs_s;
            if (settle_cnt != SETTLE_MAX) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else if (cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        miso_oe    = (state == ST_RD) || (state == ST_STAT);
        if (cs_rise) begin
            state_next = ST_IDLE;
        end else if (cs_fall) begin
            state_next = ST_CMD;
        end else if (byte_done) begin
            case (state)
                ST_CMD: begin
                    case (rx_byte)
                        CMD_READ:  state_next = ST_ADDR;
                        CMD_WRITE: state_next = wel_q ? ST_ADDR : ST_IGNORE;
                        CMD_RDSR:  state_next = ST_STAT;
                        default:   state_next = ST_IGNORE;
                    endcase
                end
                ST_ADDR: begin
                    if (addr_byte == 2'd2) begin
                        state_next = is_read ? ST_RD : ST_WR;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            bit_cnt      <= '0;
            addr_byte    <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            addr         <= '0;
            is_read      <= 1'b0;
            wel_q        <= 1'b0;
            wel_set_pend <= 1'b0;
            wel_clr_pend <= 1'b0;
            miso_q       <= 1'b0;
        end else if (cs_fall) begin
            bit_cnt      <= '0;
            addr_byte    <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            is_read      <= 1'b0;
            wel_set_pend <= 1'b0;
            wel_clr_pend <= 1'b0;
            miso_q       <= 1'b0;
        end else if (cs_rise) begin
            if (wel_set_pend) begin
                wel_q <= 1'b1;
            end else if (wel_clr_pend) begin
                wel_q <= 1'b0;
            end
            wel_set_pend <= 1'b0;
            wel_clr_pend <= 1'b0;
            bit_cnt      <= '0;
            miso_q       <= 1'b0;
        end else if (sclk_rise && state != ST_IDLE) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 1'b1;
            case (state)
                ST_CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            CMD_READ: is_read <= 1'b1;
                            // Any decoded WRITE frame drops WEL when CS rises.
                            CMD_WRITE: wel_clr_pend <= 1'b1;
                            // Preloaded so bit 7 leaves on the next sclk fall.
                            CMD_RDSR: tx_shift <= status_byte;
                            CMD_WREN: wel_set_pend <= 1'b1;
                            CMD_WRDI: wel_clr_pend <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_ADDR: begin
                    addr <= addr_shifted;
                    if (byte_done) begin
                        addr_byte <= addr_byte + 1'b1;
                        if (addr_byte == 2'd2 && is_read) begin
                            tx_shift <= mem[addr_shifted];
                        end
                    end
                end
                ST_RD: begin
                    if (byte_done) begin
                        addr     <= addr_inc;
                        tx_shift <= mem[addr_inc];
                    end
                end
                ST_WR: begin
                    if (byte_done) begin
                        mem[addr] <= rx_byte;
                        addr      <= addr_inc;
                    end
                end
                ST_STAT: begin
                    if (byte_done) begin
                        tx_shift <= status_byte;
                    end
                end
                default: ;
            endcase
        end else if (sclk_fall && (state == ST_RD || state == ST_STAT)) begin
            miso_q   <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb/tb_spi_mem_responder.sv - directed self-checking bench for spi_mem_responder
module tb_spi_mem_responder;

    localparam int HALF = 6;

    logic clk;
    logic rst;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;
    logic selected;
    logic wel;

    int checks;
    int failures;

    spi_mem_responder #(
        .ADDR_BITS  (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .selected(selected),
        .wel     (wel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin();
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_end();
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Clocks nbits of tx (MSB first); miso is captured just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            wait_clk(HALF);
            rx[i] = miso;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic one_byte_frame(input logic [7:0] cmd);
        logic [7:0] rx;
        spi_begin();
        spi_byte(cmd, rx);
        spi_end();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(4);
        checks += 4;
        if (miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", miso); end
        if (miso_oe !== 1'b0) begin failures++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
        if (selected !== 1'b0) begin failures++; $display("FAIL reset_selected got=%b exp=0", selected); end
        if (wel !== 1'b0) begin failures++; $display("FAIL reset_wel got=%b exp=0", wel); end
        rst = 1'b0;
        wait_clk(8);
    endtask

    task automatic test_rdsr_after_reset();
        logic [7:0] rx;
        spi_begin();
        checks++;
        if (selected !== 1'b1) begin failures++; $display("FAIL rdsr_selected got=%b exp=1", selected); end
        spi_byte(8'h05, rx);
        wait_clk(2);
        checks++;
        if (miso_oe !== 1'b1) begin failures++; $display("FAIL rdsr_oe got=%b exp=1", miso_oe); end
        spi_byte(8'h00, rx);
        checks++;
        if (rx !== 8'h00) begin failures++; $display("FAIL rdsr_reset_status got=%h exp=00", rx); end
        spi_end();
        checks++;
        if (miso_oe !== 1'b0) begin failures++; $display("FAIL rdsr_oe_after_cs got=%b exp=0", miso_oe); end
    endtask

    task automatic test_write_without_wren();
        logic [7:0] rx;
        spi_begin();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'hA5, rx);
        spi_end();
        spi_begin();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_end();
        checks++;
        if (rx !== 8'h00) begin failures++; $display("FAIL nowren_read got=%h exp=00", rx); end
    endtask

    task automatic test_write_wrap();
        logic [7:0] rx;
        logic [7:0] exp_bytes [4];
        exp_bytes[0] = 8'h11;
        exp_bytes[1] = 8'h22;
        exp_bytes[2] = 8'h33;
        exp_bytes[3] = 8'h00;
        one_byte_frame(8'h06);
        checks++;
        if (wel !== 1'b1) begin failures++; $display("FAIL wren_wel got=%b exp=1", wel); end
        spi_begin();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h0E, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        spi_byte(8'h33, rx);
        spi_end();
        checks++;
        if (wel !== 1'b0) begin failures++; $display("FAIL write_clears_wel got=%b exp=0", wel); end
        spi_begin();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h0E, rx);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, rx);
            checks++;
            if (rx !== exp_bytes[i]) begin
                failures++;
                $display("FAIL wrap_read[%0d] got=%h exp=%h", i, rx, exp_bytes[i]);
            end
        end
        spi_end();
        spi_begin();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        spi_end();
        checks++;
        if (rx !== 8'h00) begin failures++; $display("FAIL status_after_write got=%h exp=00", rx); end
    endtask

    task automatic test_wel_status();
        logic [7:0] rx;
        one_byte_frame(8'h06);
        spi_begin();
        spi_byte(8'h05, rx);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'h00, rx);
            checks++;
            if (rx !== 8'h02) begin failures++; $display("FAIL wel_status[%0d] got=%h exp=02", i, rx); end
        end
        spi_end();
        one_byte_frame(8'h04);
        checks++;
        if (wel !== 1'b0) begin failures++; $display("FAIL wrdi_wel got=%b exp=0", wel); end
        spi_begin();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        spi_end();
        checks++;
        if (rx !== 8'h00) begin failures++; $display("FAIL wrdi_status got=%h exp=00", rx); end
    endtask

    task automatic test_partial_byte();
        logic [7:0] rx;
        one_byte_frame(8'h06);
        spi_begin();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h05, rx);
        spi_byte(8'hC3, rx);
        spi_bits(8'hFF, 4, rx);
        spi_end();
        spi_begin();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        checks++;
        if (rx !== 8'hC3) begin failures++; $display("FAIL partial_mem5 got=%h exp=c3", rx); end
        spi_byte(8'h00, rx);
        checks++;
        if (rx !== 8'h00) begin failures++; $display("FAIL partial_mem6 got=%h exp=00", rx); end
        spi_end();
    endtask

    task automatic test_rst_midframe();
        logic [7:0] rx;
        one_byte_frame(8'h06);
        spi_begin();
        spi_byte(8'h03, rx);
        spi_bits(8'h00, 4, rx);
        rst = 1'b1;
        #1;
        checks += 2;
        if (miso_oe !== 1'b0) begin failures++; $display("FAIL midrst_oe got=%b exp=0", miso_oe); end
        if (wel !== 1'b0) begin failures++; $display("FAIL midrst_wel got=%b exp=0", wel); end
        wait_clk(3);
        rst = 1'b0;
        // Remaining address nibble/bytes and a would-be data byte.
        spi_bits(8'h0E, 4, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h0E, rx);
        spi_byte(8'h00, rx);
        checks += 2;
        if (miso_oe !== 1'b0) begin failures++; $display("FAIL midrst_ignored_oe got=%b exp=0", miso_oe); end
        if (rx !== 8'h00) begin failures++; $display("FAIL midrst_ignored_data got=%h exp=00", rx); end
        spi_end();
        spi_begin();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        spi_end();
        checks++;
        if (rx !== 8'h00) begin failures++; $display("FAIL midrst_status got=%h exp=00", rx); end
        // Memory was wiped by reset: address 0xE previously held 0x11.
        spi_begin();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h0E, rx);
        spi_byte(8'h00, rx);
        spi_end();
        checks++;
        if (rx !== 8'h00) begin failures++; $display("FAIL midrst_mem_cleared got=%h exp=00", rx); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_rdsr_after_reset();
        test_write_without_wren();
        test_write_wrap();
        test_wel_status();
        test_partial_byte();
        test_rst_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

Synthesizable SPI mode-0 memory responder that models the serial memory device on the far side of the crypto memory interface. It decodes command/address/data frames from an SPI initiator, serves reads from and accepts writes into a small byte-wide register array, and reports a status register. It sits beside `tt_um_mem_toplevel` in loopback builds and in the bench as the device the top level talks to. All SPI inputs are oversampled in the system clock domain.

## Interface
Parameters:
- `ADDR_BITS`, 4: storage is 2^ADDR_BITS bytes; the low ADDR_BITS bits of the 24-bit SPI address are used.
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `cs_n` and `mosi`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sclk`  in  1  SPI clock from the initiator, idle low.
- `cs_n`  in  1  chip select, active low.
- `mosi`  in  1  serial data from the initiator, MSB first.
- `miso`  out  1  serial data to the initiator, MSB first.
- `miso_oe`  out  1  high while the responder drives `miso`.
- `selected`  out  1  registered, synchronized `~cs_n`.
- `wel`  out  1  write-enable latch, mirrored into status bit 1.

## Operation
- Synchronize `sclk`, `cs_n` and `mosi` through SYNC_STAGES flops. Rising and falling edges of `sclk` are detected against the previous synchronized sample.
- Sample `mosi` on each detected `sclk` rise. Shift `miso` on each detected `sclk` fall.
- Bit counter: 3 bits. A byte completes on the 8th rise.
- States:
  - IDLE: waits for `cs_n` fall; then bit counter=0 -> CMD.
  - CMD: after 8 bits, decode the command:
    - 0x03 READ -> ADDR.
    - 0x02 WRITE -> ADDR if WEL=1, else IGNORE.
    - 0x05 RDSR -> STAT. The status byte is preloaded so its bit 7 appears on the first `sclk` fall.
    - 0x06 WREN -> sets WEL at `cs_n` rise, then IGNORE.
    - 0x04 WRDI -> clears WEL at `cs_n` rise, then IGNORE.
    - Any other command -> IGNORE.
  - ADDR: 24 bits, MSB first. Keep the low ADDR_BITS bits. Then READ goes to RD and WRITE goes to WR.
  - RD: load mem[addr] into the shifter when ADDR completes. Shift it out on falls, and reload at each byte boundary with the incremented address.
  - WR: on the 8th bit, write the byte to mem[addr] and increment addr.
  - STAT: repeats the status byte {6'b0, WEL, WIP=0} for as long as CS stays low.
  - IGNORE: consumes bits with no effect.
- Address increments modulo 2^ADDR_BITS, so 0xF wraps to 0x0 when ADDR_BITS=4.
- A synchronized `cs_n` rise in any state returns the block to IDLE:
  - A partial byte is discarded and never written.
  - Pending WREN/WRDI takes effect.
  - Any completed WRITE frame clears WEL, even if 0 data bytes were written.
- `miso_oe`=1 only in RD and STAT. Otherwise `miso`=0 and `miso_oe`=0.
- Reset clears memory to 0x00, WEL=0, state IDLE and all shifters/counters.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `selected`=0, `wel`=0.
- Input latency: SYNC_STAGES+1 `clk` cycles from pin to internal edge detect.
- `miso` updates 1 `clk` after the detected fall. Worst case is 4 `clk` after the pin edge with defaults.
- Requirement: `sclk` high and low phases are each ≥ 4 `clk` periods; CS setup/hold to the first/last `sclk` edge is ≥ 4 `clk`.
- `miso_oe` asserts 1 `clk` after the last ADDR bit (READ) or last CMD bit (RDSR). It deasserts 1 `clk` after the synchronized `cs_n` rise.
- Memory write happens 1 `clk` after the 8th detected rise of a data byte.
- WEL updates 1 `clk` after the synchronized `cs_n` rise.
- If `rst` is asserted mid-frame, all state clears immediately. The block then ignores the remaining bits until a new `cs_n` fall.
- A `cs_n` fall and an `sclk` edge detected in the same cycle: the CS edge takes priority, and that `sclk` edge is ignored.

## Test plan
- Reset, then RDSR (0x05) -> `miso` shifts 0x00, and `miso_oe`=1 during the data byte.
- WRITE without WREN: 0x02, addr 0x000003, data 0xA5; then READ at addr 3 -> returns 0x00.
- WREN (0x06); WRITE 0x02, addr 0x00000E, data 0x11 0x22 0x33 (0x33 wraps to addr 0x0); then READ from 0x00000E for 3 bytes -> 0x11, 0x22, 0x33. RDSR afterwards -> 0x00, because WEL was cleared.
- WREN then RDSR -> 0x02 repeated for 2 bytes. Then WRDI, RDSR -> 0x00.
- WREN; WRITE at addr 5 with 0xC3 followed by only 4 bits of 0xFF, then CS rise -> mem[5]=0xC3 and mem[6]=0x00.
- Assert `rst` after 12 bits of a READ frame -> `miso_oe`=0 and `wel`=0 immediately. Subsequent bits are ignored. The next full frame, RDSR, returns 0x00.
